// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, syncs and
// text-mode character-cell addressing, all outputs aligned to the counters.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CLK_DIV    = 4,
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  en_i,
    output logic                  pix_en_o,
    output logic [9:0]            hcnt_o,
    output logic [9:0]            vcnt_o,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  active_o,
    output logic                  frame_start_o,
    output logic [ADDR_WIDTH-1:0] char_addr_o,
    output logic [2:0]            glyph_x_o,
    output logic [3:0]            glyph_y_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]            H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]            V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]            H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0]            V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0]            HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]            HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]            VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]            VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [ADDR_WIDTH-1:0] COLS     = ADDR_WIDTH'(H_ACTIVE / 8);

    // row * COLS + col, with the constant multiply unrolled into shift-adds
    function automatic logic [ADDR_WIDTH-1:0] cell_addr(input logic [9:0] h,
                                                        input logic [9:0] v);
        logic [ADDR_WIDTH-1:0] row;
        logic [ADDR_WIDTH-1:0] acc;
        row = ADDR_WIDTH'(v[9:4]);
        acc = ADDR_WIDTH'(h[9:3]);
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            if (COLS[i]) acc = acc + (row << i);
        end
        return acc;
    endfunction

    logic [DIV_W-1:0]      div_q, div_d;
    logic [9:0]            hcnt_q, hcnt_d;
    logic [9:0]            vcnt_q, vcnt_d;
    logic                  pix_en_q, pix_en_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic                  active_q, active_d;
    logic                  fstart_q, fstart_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    always_comb begin
        div_d    = '0;
        hcnt_d   = '0;
        vcnt_d   = '0;
        fstart_d = 1'b0;
        if (en_i) begin
            div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            hcnt_d = hcnt_q;
            vcnt_d = vcnt_q;
            if (pix_en_q) begin
                if (hcnt_q == H_LAST) begin
                    hcnt_d = '0;
                    if (vcnt_q == V_LAST) begin
                        vcnt_d   = '0;
                        fstart_d = 1'b1;
                    end else begin
                        vcnt_d = vcnt_q + 10'd1;
                    end
                end else begin
                    hcnt_d = hcnt_q + 10'd1;
                end
            end
        end
        // Decode from the next counter values so outputs land with the counters
        pix_en_d = en_i && (div_d == DIV_LAST);
        hsync_d  = !((hcnt_d >= HS_START) && (hcnt_d < HS_END));
        vsync_d  = !((vcnt_d >= VS_START) && (vcnt_d < VS_END));
        active_d = en_i && (hcnt_d < H_VIS) && (vcnt_d < V_VIS);
        addr_d   = active_d ? cell_addr(hcnt_d, vcnt_d) : '0;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            div_q    <= '0;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            pix_en_q <= 1'b0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            active_q <= 1'b0;
            fstart_q <= 1'b0;
            addr_q   <= '0;
        end else begin
            div_q    <= div_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            pix_en_q <= pix_en_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
            fstart_q <= fstart_d;
            addr_q   <= addr_d;
        end
    end

    assign pix_en_o      = pix_en_q;
    assign hcnt_o        = hcnt_q;
    assign vcnt_o        = vcnt_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign active_o      = active_q;
    assign frame_start_o = fstart_q;
    assign char_addr_o   = addr_q;
    assign glyph_x_o     = hcnt_q[2:0];
    assign glyph_y_o     = vcnt_q[3:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster: an arithmetic model of the
// raster position pushes expected outputs per edge, a scoreboard compares them.
module tb_vga_timing_gen;

    localparam int HA = 64, HF = 8, HS = 16, HB = 8;
    localparam int VA = 48, VF = 3, VS = 2, VB = 3;
    localparam int CD = 2, AW = 13;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT * CD;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          en = 1'b0;
    logic          pix_en, hsync, vsync, active, fstart;
    logic [9:0]    hcnt, vcnt;
    logic [AW-1:0] addr;
    logic [2:0]    gx;
    logic [3:0]    gy;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(CD), .ADDR_WIDTH(AW)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .en_i(en),
        .pix_en_o(pix_en), .hcnt_o(hcnt), .vcnt_o(vcnt),
        .hsync_o(hsync), .vsync_o(vsync), .active_o(active),
        .frame_start_o(fstart), .char_addr_o(addr),
        .glyph_x_o(gx), .glyph_y_o(gy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic          pix;
        logic [9:0]    h;
        logic [9:0]    v;
        logic          hs;
        logic          vs;
        logic          act;
        logic          fs;
        logic [AW-1:0] addr;
        logic [2:0]    gx;
        logic [3:0]    gy;
    } exp_t;

    // k = number of enabled edges since the generator left idle (0 = idle)
    function automatic exp_t model_at(input int k);
        exp_t e;
        int p, h, v;
        e.pix = 1'b0; e.h = '0; e.v = '0; e.hs = 1'b1; e.vs = 1'b1;
        e.act = 1'b0; e.fs = 1'b0; e.addr = '0; e.gx = '0; e.gy = '0;
        if (k > 0) begin
            p = k / CD;
            h = p % HT;
            v = (p / HT) % VT;
            e.pix  = (k % CD) == CD - 1;
            e.h    = 10'(h);
            e.v    = 10'(v);
            e.hs   = !(h >= HA + HF && h < HA + HF + HS);
            e.vs   = !(v >= VA + VF && v < VA + VF + VS);
            e.act  = (h < HA) && (v < VA);
            e.fs   = (k % CD == 0) && (p > 0) && (p % (HT * VT) == 0);
            e.addr = e.act ? AW'((v / 16) * (HA / 8) + h / 8) : '0;
            e.gx   = 3'(h % 8);
            e.gy   = 4'(v % 16);
        end
        return e;
    endfunction

    int   n = 0;
    int   cyc = 0;
    exp_t sb[$];

    always @(posedge clk) begin
        int nn;
        nn = (rstn && en) ? n + 1 : 0;
        n <= nn;
        cyc <= cyc + 1;
        sb.push_back(model_at(nn));
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_val("sb_pix_en", 32'(pix_en), 32'(e.pix));
            check_val("sb_hcnt",   32'(hcnt),   32'(e.h));
            check_val("sb_vcnt",   32'(vcnt),   32'(e.v));
            check_val("sb_hsync",  32'(hsync),  32'(e.hs));
            check_val("sb_vsync",  32'(vsync),  32'(e.vs));
            check_val("sb_active", 32'(active), 32'(e.act));
            check_val("sb_fstart", 32'(fstart), 32'(e.fs));
            check_val("sb_addr",   32'(addr),   32'(e.addr));
            check_val("sb_gx",     32'(gx),     32'(e.gx));
            check_val("sb_gy",     32'(gy),     32'(e.gy));
        end
    end

    initial begin
        int t0, t1, lw;
        #1 rstn = 1'b0;
        #1;
        check_val("rst_hsync",  32'(hsync),  32'd1);
        check_val("rst_vsync",  32'(vsync),  32'd1);
        check_val("rst_hcnt",   32'(hcnt),   32'd0);
        check_val("rst_vcnt",   32'(vcnt),   32'd0);
        check_val("rst_pix_en", 32'(pix_en), 32'd0);
        check_val("rst_active", 32'(active), 32'd0);
        check_val("rst_fstart", 32'(fstart), 32'd0);
        check_val("rst_addr",   32'(addr),   32'd0);

        repeat (3) @(negedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(negedge clk);
        #1 en = 1'b1;
        repeat (CD) @(negedge clk);
        check_val("first_hcnt", 32'(hcnt), 32'd1);
        check_val("first_hs",   32'(hsync), 32'd1);
        check_val("first_vs",   32'(vsync), 32'd1);

        // Horizontal sync width and line period
        for (int i = 0; i < 4 * HT * CD && hsync; i++) @(negedge clk);
        check_val("hs_fall_seen", 32'(hsync), 32'd0);
        t0 = cyc;
        lw = 0;
        while (!hsync && lw < 4 * HT * CD) begin @(negedge clk); lw++; end
        check_val("hs_width", 32'(lw), 32'(HS * CD));
        for (int i = 0; i < 4 * HT * CD && hsync; i++) @(negedge clk);
        t1 = cyc;
        check_val("hs_period", 32'(t1 - t0), 32'(HT * CD));

        // Vertical sync width
        for (int i = 0; i < 2 * FRAME && vsync; i++) @(negedge clk);
        check_val("vs_fall_seen", 32'(vsync), 32'd0);
        lw = 0;
        while (!vsync && lw < FRAME) begin @(negedge clk); lw++; end
        check_val("vs_width", 32'(lw), 32'(VS * HT * CD));

        // Frame start width and period
        for (int i = 0; i < 2 * FRAME && !fstart; i++) @(negedge clk);
        check_val("fs_seen", 32'(fstart), 32'd1);
        check_val("fs_at_origin", 32'(hcnt) + 32'(vcnt), 32'd0);
        t0 = cyc;
        @(negedge clk);
        check_val("fs_width", 32'(fstart), 32'd0);
        for (int i = 0; i < 2 * FRAME && !fstart; i++) @(negedge clk);
        t1 = cyc;
        check_val("fs_period", 32'(t1 - t0), 32'(FRAME));

        // Character-cell address map corners
        for (int i = 0; i < 2 * FRAME && !(hcnt == 10'(HA - 1) && vcnt == 10'(VA - 1)); i++)
            @(negedge clk);
        check_val("last_vis_addr", 32'(addr),   32'd23);
        check_val("last_vis_gx",   32'(gx),     32'd7);
        check_val("last_vis_gy",   32'(gy),     32'd15);
        check_val("last_vis_act",  32'(active), 32'd1);
        for (int i = 0; i < 4 * CD && hcnt == 10'(HA - 1); i++) @(negedge clk);
        check_val("blank_hcnt", 32'(hcnt),   32'(HA));
        check_val("blank_act",  32'(active), 32'd0);
        check_val("blank_addr", 32'(addr),   32'd0);
        for (int i = 0; i < 2 * FRAME && !(hcnt == 10'd8 && vcnt == 10'd16); i++) @(negedge clk);
        check_val("cell_8_16_addr", 32'(addr), 32'd9);

        // Enable dropped mid-frame, then restored
        for (int i = 0; i < 2 * FRAME && !(hcnt == 10'd30 && vcnt == 10'd20); i++) @(negedge clk);
        check_val("en_drop_pos", 32'(hcnt), 32'd30);
        #1 en = 1'b0;
        @(negedge clk);
        check_val("en_off_hcnt",  32'(hcnt),   32'd0);
        check_val("en_off_vcnt",  32'(vcnt),   32'd0);
        check_val("en_off_hs",    32'(hsync),  32'd1);
        check_val("en_off_vs",    32'(vsync),  32'd1);
        check_val("en_off_act",   32'(active), 32'd0);
        repeat (3) @(negedge clk);
        #1 en = 1'b1;
        for (int i = 0; i < 4 * CD; i++) begin
            @(negedge clk);
            check_val("resume_no_fs", 32'(fstart), 32'd0);
        end
        check_val("resume_hcnt", 32'(hcnt), 32'd4);

        // Asynchronous reset while in horizontal sync
        for (int i = 0; i < 4 * HT * CD && hsync; i++) @(negedge clk);
        check_val("pre_arst_hs", 32'(hsync), 32'd0);
        #1 rstn = 1'b0;
        #1;
        check_val("arst_hsync", 32'(hsync), 32'd1);
        check_val("arst_hcnt",  32'(hcnt),  32'd0);
        check_val("arst_vcnt",  32'(vcnt),  32'd0);
        @(negedge clk);
        #1 rstn = 1'b1;
        repeat (300) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
